if_id_pipe_reg: RTL
===================

Name: if_id_pipe_reg

Overview:
- IF/ID pipeline register, directly downstream of the IF-stage instruction memory.
- Latches the fetched instruction word and PC+4 each cycle, and pre-decodes fixed fields for the ID stage.
- Supports hazard-unit stall, branch/jump flush and an input fetch-valid qualifier.
- Detects the halt/fill pattern (opcode 6'b111111, returned for empty memory and PC init) and freezes the front end after it.

Parameters:
- HALT_OP, 6'b111111, opcode that marks end of program.
- NOP_WORD, 32'h00000000, word injected as bubble (sll $0,$0,0).
- BCNT_W, 16, width of saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch word is real (0 while PC is at init value -4)
- pc_plus4_in  in  32  PC+4 from IF
- instru_in  in  32  instruction word from instruction memory
- stall  in  1  hazard unit: hold register contents
- flush  in  1  branch/jump taken: discard IF word
- pc_plus4_out  out  32  latched PC+4
- instru_out  out  32  latched instruction
- ctr_out  out  6  instru_out[31:26]
- funcode_out  out  6  instru_out[5:0]
- rs_out  out  5  instru_out[25:21]
- rt_out  out  5  instru_out[20:16]
- rd_out  out  5  instru_out[15:11]
- imm_out  out  16  instru_out[15:0]
- valid_out  out  1  ID stage holds a real instruction
- halted  out  1  halt pattern consumed; front end frozen
- instr_count  out  32  number of valid instructions loaded (wraps)
- bubble_count  out  BCNT_W  stall/flush cycles (saturates at all-ones)

Behaviour:
- All outputs are registered; decoded fields always derive from the same latched word as instru_out, with no combinational path from inputs.
- Reset (rst=1 at posedge): instru_out=NOP_WORD, pc_plus4_out=0, all decoded fields=0, valid_out=0, halted=0, instr_count=0, bubble_count=0, state=RUN. Reset overrides everything, including HALTED.
- States: RUN, HALTED.
- RUN, per posedge, priority flush > stall > load:
  - flush=1: load NOP_WORD, pc_plus4_out=0, valid_out=0, bubble_count+1. Applies even if stall=1 or instru_in is the halt pattern.
  - stall=1, flush=0: hold every output unchanged, bubble_count+1.
  - Load with if_valid=0: load NOP_WORD, valid_out=0, pc_plus4_out=pc_plus4_in. Counters unchanged; no halt detection.
  - Load with if_valid=1 and instru_in[31:26]==HALT_OP: load NOP_WORD, valid_out=0, pc_plus4_out=pc_plus4_in, halted=1, go to HALTED. The halt word itself is never presented as valid.
  - Load with if_valid=1, other opcode: latch instru_in and pc_plus4_in, valid_out=1, instr_count+1 (mod 2^32).
- HALTED: ignore stall, flush, if_valid and data inputs; hold NOP_WORD, valid_out=0, halted=1. Counters are frozen. Leave only via rst.
- Latency: an instruction presented at edge N appears on the outputs after edge N. One-cycle register.
- bubble_count saturates: at all-ones it stays all-ones on further stall/flush cycles.

Test Plan:
1. Reset, then if_valid=1, instru_in=32'h012A4020 (add $8,$9,$10), pc_plus4_in=4 -> after 1 edge: valid_out=1, ctr_out=0, funcode_out=6'h20, rs=9, rt=10, rd=8, pc_plus4_out=4, instr_count=1.
2. Load 32'h8D090004, then stall=1 for 3 cycles while inputs change -> outputs stay 32'h8D090004/valid=1, bubble_count=3, instr_count unchanged.
3. flush=1 and stall=1 together with instru_in=32'h012A4020 -> instru_out=0, valid_out=0, pc_plus4_out=0, bubble_count+1.
4. if_valid=0 with instru_in=32'hFC000000 (PC init) -> NOP loaded, valid_out=0, halted=0. Then if_valid=1 with 32'hFC000000 -> halted=1. Subsequent valid loads/flushes are ignored; rst returns all outputs to reset values.
5. flush=1 coincident with halt word -> halted stays 0, NOP loaded. A following normal word loads with valid_out=1.
6. Hold stall=1 for 65540 cycles (BCNT_W=16) -> bubble_count stops at 16'hFFFF.

Source files
------------

// File: rtl/if_id_pipe_reg_if.sv
// if_id_pipe_reg_if: IF-side inputs and ID-side decoded outputs of the IF/ID register
interface if_id_pipe_reg_if #(parameter int BCNT_W = 16);
  logic              if_valid;
  logic [31:0]       pc_plus4_in;
  logic [31:0]       instru_in;
  logic              stall;
  logic              flush;
  logic [31:0]       pc_plus4_out;
  logic [31:0]       instru_out;
  logic [5:0]        ctr_out;
  logic [5:0]        funcode_out;
  logic [4:0]        rs_out;
  logic [4:0]        rt_out;
  logic [4:0]        rd_out;
  logic [15:0]       imm_out;
  logic              valid_out;
  logic              halted;
  logic [31:0]       instr_count;
  logic [BCNT_W-1:0] bubble_count;
  modport master (
    output if_valid, pc_plus4_in, instru_in, stall, flush,
    input  pc_plus4_out, instru_out, ctr_out, funcode_out, rs_out, rt_out, rd_out,
           imm_out, valid_out, halted, instr_count, bubble_count
  );
  modport slave (
    input  if_valid, pc_plus4_in, instru_in, stall, flush,
    output pc_plus4_out, instru_out, ctr_out, funcode_out, rs_out, rt_out, rd_out,
           imm_out, valid_out, halted, instr_count, bubble_count
  );
endinterface

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID pipeline register with stall/flush, halt detection and pre-decode
module if_id_pipe_reg #(
  parameter logic [5:0]  HALT_OP  = 6'b111111,
  parameter logic [31:0] NOP_WORD = 32'h00000000,
  parameter int          BCNT_W   = 16
) (
  input logic clk,
  input logic rst,
  if_id_pipe_reg_if.slave b
);
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;
  logic [0:0]        state;
  logic [31:0]       instr;
  logic [31:0]       pc;
  logic              valid;
  logic [31:0]       icnt;
  logic [BCNT_W-1:0] bcnt;
  logic [BCNT_W-1:0] bcnt_nxt;
  assign bcnt_nxt = &bcnt ? bcnt : bcnt + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      instr <= NOP_WORD;
      pc    <= '0;
      valid <= 1'b0;
      icnt  <= '0;
      bcnt  <= '0;
    end else if (state == RUN) begin
      if (b.flush) begin
        instr <= NOP_WORD;
        pc    <= '0;
        valid <= 1'b0;
        bcnt  <= bcnt_nxt;
      end else if (b.stall) begin
        bcnt  <= bcnt_nxt;
      end else if (!b.if_valid || b.instru_in[31:26] == HALT_OP) begin
        // the halt word is swallowed as a bubble so ID never sees it as valid
        instr <= NOP_WORD;
        pc    <= b.pc_plus4_in;
        valid <= 1'b0;
        state <= b.if_valid ? HALTED : RUN;
      end else begin
        instr <= b.instru_in;
        pc    <= b.pc_plus4_in;
        valid <= 1'b1;
        icnt  <= icnt + 32'd1;
      end
    end
  end
  // decoded fields are slices of the latched word, so they stay aligned with instru_out
  assign b.instru_out   = instr;
  assign b.pc_plus4_out = pc;
  assign b.ctr_out      = instr[31:26];
  assign b.funcode_out  = instr[5:0];
  assign b.rs_out       = instr[25:21];
  assign b.rt_out       = instr[20:16];
  assign b.rd_out       = instr[15:11];
  assign b.imm_out      = instr[15:0];
  assign b.valid_out    = valid;
  assign b.halted       = state == HALTED;
  assign b.instr_count  = icnt;
  assign b.bubble_count = bcnt;
endmodule
